icache_fill_ctrl: RTL and testbench
===================================

Name: icache_fill_ctrl

Overview:
L1 instruction-cache miss/fill controller sitting directly upstream of the L2 instruction memory port. It accepts one miss at a time from the L1 lookup stage, issues a line read to L2 (mem_re/addr), and waits for the L2 ready pulse. It then checks the returned tag/index against the outstanding miss and issues a single-cycle fill write into the L1 tag/data arrays. Line address = addr[31:OFFSET_BITS+3] (8-byte instructions).

Parameters:
OFFSET_BITS, 2, log2 instructions per line
INDEX_BITS, 5, L1 index width
TAG_BITS, 22, 32-INDEX_BITS-OFFSET_BITS-3
LINE_SIZE, 256, line width in bits (2^OFFSET_BITS x 64)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
miss_valid_i  in  1  L1 miss request
miss_addr_i  in  32  missing fetch address (any byte in line)
miss_ready_o  out  1  controller can accept a miss this cycle
flush_i  in  1  pipeline/cache flush; cancels the pending fill
mem_addr_o  out  32  line-aligned L2 read address (low OFFSET_BITS+3 bits zero)
mem_re_o  out  1  L2 read strobe, one-cycle pulse per request
mem_data_i  in  LINE_SIZE  L2 line data
mem_data_ready_i  in  1  L2 data valid
mem_tag_i  in  TAG_BITS  tag of returned line
mem_index_i  in  INDEX_BITS  index of returned line
fill_valid_o  out  1  one-cycle L1 array write enable
fill_tag_o  out  TAG_BITS  tag to write
fill_index_o  out  INDEX_BITS  set to write
fill_data_o  out  LINE_SIZE  line to write
fill_err_o  out  1  sticky: L2 returned a tag/index mismatch

Behaviour:
- Clock clk; reset reset is synchronous, active-high. All outputs are registered.
- Reset values: state IDLE; miss_ready_o=1; mem_re_o=0; mem_addr_o=0; fill_valid_o=0; fill_tag_o/index/data=0; fill_err_o=0. Reset mid-operation abandons the miss; a late mem_data_ready_i is ignored.
- FSM states: IDLE, REQ, WAIT, FILL.
- IDLE: on miss_valid_i && miss_ready_o, latch the line-aligned address and expected tag/index, and go to REQ. miss_ready_o is 1 only in IDLE. miss_valid_i in any other state is ignored, not queued.
- REQ: mem_re_o=1 for exactly this cycle, with mem_addr_o valid. mem_addr_o holds its value until the next request. Next state is WAIT.
- WAIT: hold until mem_data_ready_i=1, then capture data/tag/index and go to FILL. No timeout.
- FILL: fill_valid_o=1 for one cycle with captured data, then go to IDLE.
- Tag check: if mem_tag_i/mem_index_i differs from the expected value at capture, suppress fill_valid_o and set fill_err_o (held until reset).
- Latency (L2 penalty P cycles after mem_re): accept at cycle T, mem_re at T+1, ready at T+1+P, fill_valid at T+2+P.
- flush_i in REQ/WAIT: the request still completes on the L2 side, but fill_valid_o is suppressed. flush_i in FILL cycle: the write still happens (already committed). flush_i in IDLE has no effect.
- Simultaneous flush_i and miss_valid_i in IDLE: the miss is accepted.
- mem_data_ready_i outside WAIT is ignored.

Optional Feature:
ICACHE_NEXT_LINE_PREFETCH_EN
- With the macro: after every FILL, the controller issues a read for line+1 (address wraps modulo 2^32) through states PF_REQ and PF_WAIT into a one-entry buffer (valid, line addr, tag, index, data).
  - A miss whose line matches a valid buffer entry goes IDLE -> FILL directly from the buffer, so fill_valid_o is high at T+1. The entry is invalidated and the next prefetch follows.
  - miss_ready_o=0 during PF_REQ/PF_WAIT.
  - flush_i invalidates the buffer; flush_i during PF_WAIT discards the result.
  - A prefetch tag mismatch sets fill_err_o and leaves the buffer invalid.
- Without the macro: the four-state FSM only; no extra storage.

Decomposition:
- Package icache_fill_pkg: state enum, OFFSET/INDEX/TAG width constants, line-align and tag/index extraction functions.
- Sub-module icache_pf_buffer (one-entry prefetch buffer with match/invalidate), instantiated only under ICACHE_NEXT_LINE_PREFETCH_EN.

Test Plan:
- Basic miss: miss_addr 0x0000_1238, L2 P=2 -> mem_re=1 with mem_addr=0x0000_1220 at T+1; fill_valid at T+4 with tag=0x4, index=0x11.
- Back-to-back: miss_valid held high for 0x1238 then 0x5000 -> second accepted only after returning to IDLE; exactly two mem_re pulses and two fills.
- Flush in WAIT: flush_i at T+2 -> no fill_valid; miss_ready_o=1 at T+4; next miss proceeds normally.
- Mismatch: L2 returns index 0x12 for the 0x1238 miss -> fill_valid stays 0; fill_err_o=1 until reset.
- Reset in WAIT: reset at T+2, ready at T+3 -> no fill; all outputs at reset values.
- Prefetch (macro on): miss 0x1238, then miss 0x1248 after prefetch completes -> mem_addr 0x1240 prefetched; second fill_valid 1 cycle after accept with index 0x12; line 0xFFFF_FFE0 prefetches 0x0000_0000.

Source files
------------

// File: rtl/icache_fill_pkg.sv
// icache_fill_pkg: shared widths, FSM state encoding and address helpers
// for the L1 instruction-cache fill controller.
// ICACHE_NEXT_LINE_PREFETCH_EN adds the PF_REQ/PF_WAIT states.
package icache_fill_pkg;

  localparam int OFFSET_BITS = 2;
  localparam int INDEX_BITS  = 5;
  localparam int TAG_BITS    = 32 - INDEX_BITS - OFFSET_BITS - 3;
  localparam int LINE_SIZE   = (1 << OFFSET_BITS) * 64;
  // Byte offset of the line address: OFFSET_BITS instruction bits + 3 byte bits.
  localparam int LINE_LSB    = OFFSET_BITS + 3;
  localparam int LINE_BYTES  = 1 << LINE_LSB;

`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
  typedef enum logic [2:0] {IDLE, REQ, WAIT, FILL, PF_REQ, PF_WAIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, REQ, WAIT, FILL} state_t;
`endif

  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return {addr[31:LINE_LSB], {LINE_LSB{1'b0}}};
  endfunction

  function automatic logic [TAG_BITS-1:0] addr_tag(input logic [31:0] addr);
    return addr[31:32-TAG_BITS];
  endfunction

  function automatic logic [INDEX_BITS-1:0] addr_index(input logic [31:0] addr);
    return addr[LINE_LSB +: INDEX_BITS];
  endfunction

endpackage

// File: rtl/icache_fill_ctrl_if.sv
// icache_fill_ctrl_if: miss request, L2 read port and L1 fill port of the
// fill controller. master = controller side, slave = pipeline/L2/array side.
interface icache_fill_ctrl_if;
  import icache_fill_pkg::*;

  logic                  miss_valid_i;
  logic [31:0]           miss_addr_i;
  logic                  miss_ready_o;
  logic                  flush_i;
  logic [31:0]           mem_addr_o;
  logic                  mem_re_o;
  logic [LINE_SIZE-1:0]  mem_data_i;
  logic                  mem_data_ready_i;
  logic [TAG_BITS-1:0]   mem_tag_i;
  logic [INDEX_BITS-1:0] mem_index_i;
  logic                  fill_valid_o;
  logic [TAG_BITS-1:0]   fill_tag_o;
  logic [INDEX_BITS-1:0] fill_index_o;
  logic [LINE_SIZE-1:0]  fill_data_o;
  logic                  fill_err_o;

  modport master (
    input  miss_valid_i, miss_addr_i, flush_i, mem_data_i, mem_data_ready_i,
           mem_tag_i, mem_index_i,
    output miss_ready_o, mem_addr_o, mem_re_o, fill_valid_o, fill_tag_o,
           fill_index_o, fill_data_o, fill_err_o
  );

  modport slave (
    output miss_valid_i, miss_addr_i, flush_i, mem_data_i, mem_data_ready_i,
           mem_tag_i, mem_index_i,
    input  miss_ready_o, mem_addr_o, mem_re_o, fill_valid_o, fill_tag_o,
           fill_index_o, fill_data_o, fill_err_o
  );

endinterface

// File: rtl/icache_pf_buffer.sv
// icache_pf_buffer: one-entry next-line prefetch buffer. Holds a line
// returned by a prefetch; reports a hit against a lookup line address.
// Only instantiated when ICACHE_NEXT_LINE_PREFETCH_EN is defined.
module icache_pf_buffer
  import icache_fill_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  invalidate,
  input  logic [31:0]           load_line,
  input  logic [TAG_BITS-1:0]   load_tag,
  input  logic [INDEX_BITS-1:0] load_index,
  input  logic [LINE_SIZE-1:0]  load_data,
  input  logic [31:0]           lookup_line,
  output logic                  hit,
  output logic [TAG_BITS-1:0]   tag,
  output logic [INDEX_BITS-1:0] index,
  output logic [LINE_SIZE-1:0]  data
);

  logic                  valid_reg;
  logic [31:0]           line_reg;
  logic [TAG_BITS-1:0]   tag_reg;
  logic [INDEX_BITS-1:0] index_reg;
  logic [LINE_SIZE-1:0]  data_reg;

  // Entry storage; invalidation wins over a same-cycle load.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg <= 1'b0;
      line_reg  <= '0;
      tag_reg   <= '0;
      index_reg <= '0;
      data_reg  <= '0;
    end else if (invalidate) begin
      valid_reg <= 1'b0;
    end else if (load) begin
      valid_reg <= 1'b1;
      line_reg  <= load_line;
      tag_reg   <= load_tag;
      index_reg <= load_index;
      data_reg  <= load_data;
    end
  end

  assign hit   = valid_reg && (line_reg == lookup_line);
  assign tag   = tag_reg;
  assign index = index_reg;
  assign data  = data_reg;

endmodule

// File: rtl/icache_fill_ctrl.sv
// icache_fill_ctrl: single-outstanding L1 I-cache miss/fill controller.
// Accepts a miss, reads the line from L2, checks the returned tag/index and
// issues a one-cycle fill write. Define ICACHE_NEXT_LINE_PREFETCH_EN to add
// a next-line prefetch into a one-entry buffer.
module icache_fill_ctrl
  import icache_fill_pkg::*;
(
  input  logic clk,
  input  logic reset,
  icache_fill_ctrl_if.master bus
);

  state_t                state_reg, state_next;
  logic [31:0]           mem_addr_reg;
  logic                  miss_ready_reg, mem_re_reg, fill_valid_reg;
  logic                  fill_err_reg, cancel_reg;
  logic [TAG_BITS-1:0]   fill_tag_reg;
  logic [INDEX_BITS-1:0] fill_index_reg;
  logic [LINE_SIZE-1:0]  fill_data_reg;
  logic                  accept, fill_from_mem, tag_mismatch;
  logic                  mem_match, cancel_now;

`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
  logic [31:0]           line_reg;
  logic                  pf_raw_hit, pf_hit, pf_take, pf_load;
  logic [TAG_BITS-1:0]   pf_tag;
  logic [INDEX_BITS-1:0] pf_index;
  logic [LINE_SIZE-1:0]  pf_data;

  icache_pf_buffer u_pf_buffer (
    .clk         (clk),
    .reset       (reset),
    .load        (pf_load),
    .invalidate  (bus.flush_i | pf_take),
    .load_line   (mem_addr_reg),
    .load_tag    (bus.mem_tag_i),
    .load_index  (bus.mem_index_i),
    .load_data   (bus.mem_data_i),
    .lookup_line (line_align(bus.miss_addr_i)),
    .hit         (pf_raw_hit),
    .tag         (pf_tag),
    .index       (pf_index),
    .data        (pf_data)
  );

  // A flush in the same cycle as the miss kills the buffered line.
  assign pf_hit = pf_raw_hit & ~bus.flush_i;
`endif

  // The outstanding request address is the reference for the tag check.
  assign mem_match  = (bus.mem_tag_i == addr_tag(mem_addr_reg)) &&
                      (bus.mem_index_i == addr_index(mem_addr_reg));
  assign cancel_now = cancel_reg | bus.flush_i;

  // Next-state and per-cycle control decode.
  always_comb begin
    state_next    = state_reg;
    accept        = 1'b0;
    fill_from_mem = 1'b0;
    tag_mismatch  = 1'b0;
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
    pf_take       = 1'b0;
    pf_load       = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (bus.miss_valid_i) begin
          accept = 1'b1;
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
          if (pf_hit) begin
            pf_take    = 1'b1;
            state_next = FILL;
          end else begin
            state_next = REQ;
          end
`else
          state_next = REQ;
`endif
        end
      end
      REQ:  state_next = WAIT;
      WAIT: begin
        if (bus.mem_data_ready_i) begin
          tag_mismatch = !mem_match;
          // Cancelled or mismatched returns skip FILL so the port frees up at once.
          if (!mem_match || cancel_now) begin
            state_next = IDLE;
          end else begin
            fill_from_mem = 1'b1;
            state_next    = FILL;
          end
        end
      end
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
      FILL:    state_next = PF_REQ;
      PF_REQ:  state_next = PF_WAIT;
      PF_WAIT: begin
        if (bus.mem_data_ready_i) begin
          tag_mismatch = !mem_match;
          pf_load      = mem_match && !cancel_now;
          state_next   = IDLE;
        end
      end
`else
      FILL:    state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  // State, registered outputs, request address and captured fill line.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      miss_ready_reg <= 1'b1;
      mem_re_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      fill_valid_reg <= 1'b0;
      fill_tag_reg   <= '0;
      fill_index_reg <= '0;
      fill_data_reg  <= '0;
      fill_err_reg   <= 1'b0;
      cancel_reg     <= 1'b0;
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
      line_reg       <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      miss_ready_reg <= (state_next == IDLE);
      fill_valid_reg <= (state_next == FILL);
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
      mem_re_reg     <= (state_next == REQ) || (state_next == PF_REQ);
      if (accept) line_reg <= line_align(bus.miss_addr_i);
      if (accept && !pf_hit) mem_addr_reg <= line_align(bus.miss_addr_i);
      if (state_reg == FILL) mem_addr_reg <= line_reg + 32'(LINE_BYTES);
      if (pf_take) begin
        fill_tag_reg   <= pf_tag;
        fill_index_reg <= pf_index;
        fill_data_reg  <= pf_data;
      end
`else
      mem_re_reg     <= (state_next == REQ);
      if (accept) mem_addr_reg <= line_align(bus.miss_addr_i);
`endif
      if (fill_from_mem) begin
        fill_tag_reg   <= bus.mem_tag_i;
        fill_index_reg <= bus.mem_index_i;
        fill_data_reg  <= bus.mem_data_i;
      end
      if (tag_mismatch) fill_err_reg <= 1'b1;
      // A flush while a read is in flight only cancels its write-back.
      if (accept) cancel_reg <= 1'b0;
      else if (bus.flush_i && state_reg != IDLE && state_reg != FILL) cancel_reg <= 1'b1;
    end
  end

  assign bus.miss_ready_o = miss_ready_reg;
  assign bus.mem_re_o     = mem_re_reg;
  assign bus.mem_addr_o   = mem_addr_reg;
  assign bus.fill_valid_o = fill_valid_reg;
  assign bus.fill_tag_o   = fill_tag_reg;
  assign bus.fill_index_o = fill_index_reg;
  assign bus.fill_data_o  = fill_data_reg;
  assign bus.fill_err_o   = fill_err_reg;

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// tb_icache_fill_ctrl: self-checking bench for icache_fill_ctrl (default
// build, ICACHE_NEXT_LINE_PREFETCH_EN undefined). A reactive L2 model answers
// each mem_re after l2_p cycles; expected fills go to a scoreboard queue.
module tb_icache_fill_ctrl;

  typedef struct packed {
    logic [21:0]  tag;
    logic [4:0]   idx;
    logic [255:0] data;
  } exp_t;

  logic clk;
  logic reset;
  icache_fill_ctrl_if bus();

  icache_fill_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   n_tests = 0;
  int   n_fail = 0;
  int   fill_cnt = 0;
  int   mem_re_cnt = 0;
  int   l2_p = 2;
  bit   l2_bad_index = 0;
  exp_t sb_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [255:0] make_line(input logic [31:0] line_addr);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = (line_addr + i * 32'h0101_0101) ^ 32'hC0DE_0000;
    return l;
  endfunction

  function automatic exp_t exp_line(input logic [31:0] addr);
    exp_t e;
    e.tag  = addr[31:10];
    e.idx  = addr[9:5];
    e.data = make_line({addr[31:5], 5'b0});
    return e;
  endfunction

  // L2 model: respond l2_p cycles after each observed read strobe.
  initial begin
    int          cnt;
    logic [31:0] a;
    cnt = 0;
    a = '0;
    bus.mem_data_ready_i = 1'b0;
    bus.mem_tag_i = '0;
    bus.mem_index_i = '0;
    bus.mem_data_i = '0;
    forever begin
      @(negedge clk);
      bus.mem_data_ready_i = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.mem_data_ready_i = 1'b1;
          bus.mem_tag_i   = a[31:10];
          bus.mem_index_i = l2_bad_index ? 5'(a[9:5] + 5'd1) : a[9:5];
          bus.mem_data_i  = make_line(a);
        end
      end
      if (bus.mem_re_o === 1'b1) begin
        cnt = l2_p;
        a = bus.mem_addr_o;
        mem_re_cnt++;
        $display("[TB] mem_re addr=%08h", bus.mem_addr_o);
      end
    end
  end

  // Fill monitor: every fill must match the oldest scoreboard entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.fill_valid_o === 1'b1) begin
        fill_cnt++;
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_fill: got tag=%h index=%h, required no fill", bus.fill_tag_o, bus.fill_index_o);
        end else begin
          e = sb_q.pop_front();
          if (bus.fill_tag_o !== e.tag || bus.fill_index_o !== e.idx || bus.fill_data_o !== e.data) begin
            n_fail++;
            $display("FAIL fill_line: got tag=%h index=%h data=%h, required tag=%h index=%h data=%h",
                     bus.fill_tag_o, bus.fill_index_o, bus.fill_data_o, e.tag, e.idx, e.data);
          end else begin
            $display("[TB] fill tag=%h index=%h ok", bus.fill_tag_o, bus.fill_index_o);
          end
        end
      end
    end
  end

  task automatic wait_fills(input int target, input string name);
    for (int i = 0; i < 40 && fill_cnt < target; i++) @(negedge clk);
    n_tests++;
    if (fill_cnt !== target) begin
      n_fail++;
      $display("FAIL %s: fills=%0d, required %0d", name, fill_cnt, target);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if (bus.miss_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_miss_ready: got %b, required 1", bus.miss_ready_o); end
    n_tests++; if (bus.mem_re_o !== 1'b0) begin n_fail++; $display("FAIL rst_mem_re: got %b, required 0", bus.mem_re_o); end
    n_tests++; if (bus.mem_addr_o !== 32'h0) begin n_fail++; $display("FAIL rst_mem_addr: got %h, required 0", bus.mem_addr_o); end
    n_tests++; if (bus.fill_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_fill_valid: got %b, required 0", bus.fill_valid_o); end
    n_tests++; if (bus.fill_tag_o !== 22'h0 || bus.fill_index_o !== 5'h0) begin n_fail++; $display("FAIL rst_fill_tag_index: got %h/%h, required 0/0", bus.fill_tag_o, bus.fill_index_o); end
    n_tests++; if (bus.fill_data_o !== 256'h0) begin n_fail++; $display("FAIL rst_fill_data: got %h, required 0", bus.fill_data_o); end
    n_tests++; if (bus.fill_err_o !== 1'b0) begin n_fail++; $display("FAIL rst_fill_err: got %b, required 0", bus.fill_err_o); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_miss();
    l2_p = 2;
    bus.miss_valid_i = 1'b1; bus.miss_addr_i = 32'h0000_1238;
    sb_q.push_back(exp_line(32'h0000_1238));
    @(negedge clk);  // T+1
    bus.miss_valid_i = 1'b0;
    n_tests++; if (bus.mem_re_o !== 1'b1) begin n_fail++; $display("FAIL basic_mem_re: got %b, required 1", bus.mem_re_o); end
    n_tests++; if (bus.mem_addr_o !== 32'h0000_1220) begin n_fail++; $display("FAIL basic_mem_addr: got %h, required 00001220", bus.mem_addr_o); end
    n_tests++; if (bus.miss_ready_o !== 1'b0) begin n_fail++; $display("FAIL basic_busy: got %b, required 0", bus.miss_ready_o); end
    @(negedge clk);  // T+2
    n_tests++; if (bus.mem_re_o !== 1'b0) begin n_fail++; $display("FAIL basic_re_pulse: got %b, required 0", bus.mem_re_o); end
    @(negedge clk);  // T+3
    n_tests++; if (bus.fill_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_early_fill: got %b, required 0", bus.fill_valid_o); end
    @(negedge clk);  // T+4
    n_tests++; if (bus.fill_valid_o !== 1'b1) begin n_fail++; $display("FAIL basic_fill_time: got %b, required 1", bus.fill_valid_o); end
    n_tests++; if (bus.fill_tag_o !== 22'h4 || bus.fill_index_o !== 5'h11) begin n_fail++; $display("FAIL basic_tag_index: got %h/%h, required 4/11", bus.fill_tag_o, bus.fill_index_o); end
    @(negedge clk);  // T+5
    n_tests++; if (bus.miss_ready_o !== 1'b1 || bus.fill_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got ready=%b fill=%b, required 1/0", bus.miss_ready_o, bus.fill_valid_o); end
  endtask

  task automatic test_back_to_back();
    int re0, f0;
    bit seen;
    re0 = mem_re_cnt; f0 = fill_cnt; seen = 0;
    l2_p = 1;
    bus.miss_valid_i = 1'b1; bus.miss_addr_i = 32'h0000_1238;
    sb_q.push_back(exp_line(32'h0000_1238));
    sb_q.push_back(exp_line(32'h0000_5000));
    @(negedge clk);
    bus.miss_addr_i = 32'h0000_5000;  // request stays asserted
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (bus.mem_re_o === 1'b1) begin
        seen = 1;
        bus.miss_valid_i = 1'b0;
        n_tests++; if (bus.mem_addr_o !== 32'h0000_5000) begin n_fail++; $display("FAIL b2b_addr2: got %h, required 00005000", bus.mem_addr_o); end
        n_tests++; if (fill_cnt - f0 !== 1) begin n_fail++; $display("FAIL b2b_order: fills before 2nd req=%0d, required 1", fill_cnt - f0); end
      end
    end
    bus.miss_valid_i = 1'b0;
    n_tests++; if (!seen) begin n_fail++; $display("FAIL b2b_timeout: second mem_re not seen, required within 30 cycles"); end
    repeat (8) @(negedge clk);
    n_tests++; if (mem_re_cnt - re0 !== 2) begin n_fail++; $display("FAIL b2b_re_count: got %0d, required 2", mem_re_cnt - re0); end
    n_tests++; if (fill_cnt - f0 !== 2) begin n_fail++; $display("FAIL b2b_fill_count: got %0d, required 2", fill_cnt - f0); end
  endtask

  task automatic test_flush_wait();
    int f0;
    l2_p = 2;
    bus.miss_valid_i = 1'b1; bus.miss_addr_i = 32'h0000_2468;
    @(negedge clk);  // T+1
    bus.miss_valid_i = 1'b0;
    @(negedge clk);  // T+2
    bus.flush_i = 1'b1;
    @(negedge clk);  // T+3
    bus.flush_i = 1'b0;
    @(negedge clk);  // T+4
    n_tests++; if (bus.fill_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_no_fill: got %b, required 0", bus.fill_valid_o); end
    n_tests++; if (bus.miss_ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b, required 1", bus.miss_ready_o); end
    @(negedge clk);
    // miss together with flush in IDLE: must still be accepted
    f0 = fill_cnt;
    bus.miss_valid_i = 1'b1; bus.flush_i = 1'b1; bus.miss_addr_i = 32'h0000_3004;
    sb_q.push_back(exp_line(32'h0000_3004));
    @(negedge clk);
    bus.miss_valid_i = 1'b0; bus.flush_i = 1'b0;
    n_tests++; if (bus.mem_re_o !== 1'b1 || bus.mem_addr_o !== 32'h0000_3000) begin n_fail++; $display("FAIL flush_idle_accept: got re=%b addr=%h, required 1/00003000", bus.mem_re_o, bus.mem_addr_o); end
    wait_fills(f0 + 1, "flush_next_fill");
    @(negedge clk);
  endtask

  task automatic test_mismatch();
    int f0;
    l2_p = 2; l2_bad_index = 1;
    bus.miss_valid_i = 1'b1; bus.miss_addr_i = 32'h0000_1238;
    @(negedge clk);
    bus.miss_valid_i = 1'b0;
    repeat (3) @(negedge clk);  // T+4
    n_tests++; if (bus.fill_valid_o !== 1'b0) begin n_fail++; $display("FAIL mm_no_fill: got %b, required 0", bus.fill_valid_o); end
    n_tests++; if (bus.fill_err_o !== 1'b1) begin n_fail++; $display("FAIL mm_err: got %b, required 1", bus.fill_err_o); end
    l2_bad_index = 0;
    @(negedge clk);
    f0 = fill_cnt;
    bus.miss_valid_i = 1'b1; bus.miss_addr_i = 32'h0000_4010;
    sb_q.push_back(exp_line(32'h0000_4010));
    @(negedge clk);
    bus.miss_valid_i = 1'b0;
    wait_fills(f0 + 1, "mm_next_fill");
    n_tests++; if (bus.fill_err_o !== 1'b1) begin n_fail++; $display("FAIL mm_err_sticky: got %b, required 1", bus.fill_err_o); end
    @(negedge clk);
  endtask

  task automatic test_reset_wait();
    l2_p = 2;
    bus.miss_valid_i = 1'b1; bus.miss_addr_i = 32'h0000_1238;
    @(negedge clk);  // T+1
    bus.miss_valid_i = 1'b0;
    @(negedge clk);  // T+2
    reset = 1'b1;
    @(negedge clk);  // T+3, late L2 data arrives here
    reset = 1'b0;
    @(negedge clk);  // T+4
    n_tests++; if (bus.fill_valid_o !== 1'b0 || bus.mem_re_o !== 1'b0) begin n_fail++; $display("FAIL rw_strobes: got fill=%b re=%b, required 0/0", bus.fill_valid_o, bus.mem_re_o); end
    n_tests++; if (bus.miss_ready_o !== 1'b1) begin n_fail++; $display("FAIL rw_ready: got %b, required 1", bus.miss_ready_o); end
    n_tests++; if (bus.mem_addr_o !== 32'h0) begin n_fail++; $display("FAIL rw_mem_addr: got %h, required 0", bus.mem_addr_o); end
    n_tests++; if (bus.fill_tag_o !== 22'h0 || bus.fill_index_o !== 5'h0 || bus.fill_data_o !== 256'h0) begin n_fail++; $display("FAIL rw_fill_regs: got tag=%h index=%h, required 0", bus.fill_tag_o, bus.fill_index_o); end
    n_tests++; if (bus.fill_err_o !== 1'b0) begin n_fail++; $display("FAIL rw_err: got %b, required 0", bus.fill_err_o); end
    repeat (3) @(negedge clk);
    n_tests++; if (bus.fill_valid_o !== 1'b0) begin n_fail++; $display("FAIL rw_late_fill: got %b, required 0", bus.fill_valid_o); end
  endtask

  initial begin
    reset = 1'b1;
    bus.miss_valid_i = 1'b0;
    bus.miss_addr_i = '0;
    bus.flush_i = 1'b0;
    test_reset();
    test_basic_miss();
    test_back_to_back();
    test_flush_wait();
    test_mismatch();
    test_reset_wait();
    repeat (4) @(negedge clk);
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expected fills never seen, required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
